seven_seg_scanner: RTL

//  Time-multiplexed driver for a 4-digit common-anode seven-segment display.

---
 rtl/seven_seg_scanner_if.sv | 22 ++
 rtl/seven_seg_scanner.sv | 82 ++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// Digit-capture and display-drive signals between the digit separator,
// the scanner and the seven-segment pins.
interface seven_seg_scanner_if;
   logic       update;
   logic [3:0] thousands;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [3:0] an_n;
   logic [6:0] seg_n;
   logic       frame_done;

   modport master (
      output update, thousands, hundreds, tens, ones,
      input  an_n, seg_n, frame_done
   );

   modport slave (
      input  update, thousands, hundreds, tens, ones,
      output an_n, seg_n, frame_done
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode seven-segment scanner: shadowed BCD digits, one blank
// cycle between digits, optional leading-zero blanking, per-frame pulse.
module seven_seg_scanner #(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input logic                clk,
   input logic                reset,
   seven_seg_scanner_if.slave bus
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [3:0][3:0] shadow;
   logic [CW-1:0]   cnt;
   logic [1:0]      idx;
   logic            tick;
   logic [3:0]      blank_lz;
   logic [3:0]      cur;
   logic [3:0]      an_nxt;
   logic [6:0]      seg_nxt;
   logic            fd_nxt;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b0111111;
      endcase
   endfunction

   assign tick = (cnt == LAST);
   assign cur  = shadow[idx];

   // A digit is a leading zero only if it and every more significant digit is 0.
   always_comb begin
      blank_lz    = 4'b0000;
      blank_lz[3] = BLANK_LZ && (shadow[3] == 4'd0);
      blank_lz[2] = blank_lz[3] && (shadow[2] == 4'd0);
      blank_lz[1] = blank_lz[2] && (shadow[1] == 4'd0);
   end

   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'h7F;
      fd_nxt  = 1'b0;
      if (tick) begin
         fd_nxt = (idx == 2'd3);
      end else if (!blank_lz[idx]) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = dec(cur);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow         <= '0;
         cnt            <= '0;
         idx            <= 2'd0;
         bus.an_n       <= 4'b1111;
         bus.seg_n      <= 7'h7F;
         bus.frame_done <= 1'b0;
      end else begin
         if (bus.update)
            shadow <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
         cnt            <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;
         bus.an_n       <= an_nxt;
         bus.seg_n      <= seg_nxt;
         bus.frame_done <= fd_nxt;
      end
   end
endmodule
